// File: rtl/f2i_seq.sv
// Multi-cycle binary32 -> int32 converter, truncating toward zero.
// The significand moves one bit per cycle through a single 32-bit shift register.
module f2i_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] d,
   output logic        p_lost,
   output logic        invalid
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] m_q, m_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        right_q, right_d;
   logic        sign_q, sign_d;
   logic        sticky_q, sticky_d;
   logic [31:0] d_q, d_d;
   logic        p_lost_q, p_lost_d;
   logic        invalid_q, invalid_d;
   logic [7:0]  e;

   assign e         = a[30:23];
   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign d         = d_q;
   assign p_lost    = p_lost_q;
   assign invalid   = invalid_q;

   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      cnt_d     = cnt_q;
      right_d   = right_q;
      sign_d    = sign_q;
      sticky_d  = sticky_q;
      d_d       = d_q;
      p_lost_d  = p_lost_q;
      invalid_d = invalid_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (e == 8'd255) begin
                  d_d       = 32'h8000_0000;
                  invalid_d = 1'b1;
                  p_lost_d  = 1'b0;
                  state_d   = DONE;
               end else if (e >= 8'd158) begin
                  // Only exactly -2^31 fits; everything else at this exponent overflows.
                  d_d       = 32'h8000_0000;
                  p_lost_d  = 1'b0;
                  invalid_d = (a != 32'hCF00_0000);
                  state_d   = DONE;
               end else if (e < 8'd127) begin
                  d_d       = '0;
                  invalid_d = 1'b0;
                  p_lost_d  = |a[30:0];
                  state_d   = DONE;
               end else begin
                  m_d      = {8'b0, 1'b1, a[22:0]};
                  sticky_d = 1'b0;
                  sign_d   = a[31];
                  right_d  = (e < 8'd150);
                  cnt_d    = (e < 8'd150) ? 5'(8'd150 - e) : 5'(e - 8'd150);
                  state_d  = SHIFT;
               end
            end
         end
         SHIFT: begin
            if (cnt_q != 5'd0) begin
               if (right_q) begin
                  m_d      = m_q >> 1;
                  sticky_d = sticky_q | m_q[0];
               end else begin
                  m_d = m_q << 1;
               end
               cnt_d = cnt_q - 5'd1;
            end else begin
               d_d       = sign_q ? (~m_q + 32'd1) : m_q;
               p_lost_d  = sticky_q;
               invalid_d = 1'b0;
               state_d   = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         m_q       <= '0;
         cnt_q     <= '0;
         right_q   <= 1'b0;
         sign_q    <= 1'b0;
         sticky_q  <= 1'b0;
         d_q       <= '0;
         p_lost_q  <= 1'b0;
         invalid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         cnt_q     <= cnt_d;
         right_q   <= right_d;
         sign_q    <= sign_d;
         sticky_q  <= sticky_d;
         d_q       <= d_d;
         p_lost_q  <= p_lost_d;
         invalid_q <= invalid_d;
      end
   end

endmodule

// File: tb/tb_f2i_seq.sv
// Self-checking bench for f2i_seq: directed corner cases, random floats against a
// real-arithmetic reference, backpressure, mid-conversion reset and i2f round trip.
module tb_f2i_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] d;
   logic        p_lost;
   logic        invalid;

   int tests = 0;
   int fails = 0;

   f2i_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d),
      .p_lost    (p_lost),
      .invalid   (invalid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: value of the float as a real number, truncated toward zero.
   task automatic ref_model(input logic [31:0] av, output logic [31:0] dx,
                            output logic pl, output logic inv);
      int   ex;
      real  x;
      real  scale;
      int   t;
      ex = int'(av[30:23]);
      if (ex == 255) begin
         dx = 32'h8000_0000; pl = 1'b0; inv = 1'b1;
      end else begin
         scale = 1.0;
         if (ex == 0) begin
            for (int i = 0; i < 149; i++) scale = scale / 2.0;
            x = real'(av[22:0]) * scale;
         end else begin
            if (ex >= 150) for (int i = 0; i < ex - 150; i++) scale = scale * 2.0;
            else           for (int i = 0; i < 150 - ex; i++) scale = scale / 2.0;
            x = (8388608.0 + real'(av[22:0])) * scale;
         end
         if (x >= 2147483648.0) begin
            dx  = 32'h8000_0000;
            pl  = 1'b0;
            inv = !(av[31] && x == 2147483648.0);
         end else begin
            t   = $rtoi(x);
            pl  = ($itor(t) != x);
            dx  = av[31] ? -t : t;
            inv = 1'b0;
         end
      end
   endtask

   function automatic int exp_latency(input logic [31:0] av);
      int ex;
      ex = int'(av[30:23]);
      if (ex == 255 || ex >= 158 || ex < 127) return 1;
      return (ex < 150) ? (150 - ex) + 2 : (ex - 150) + 2;
   endfunction

   // Integer -> float model; lost=1 when the integer is not exactly representable.
   task automatic i2f(input logic [31:0] v, output logic [31:0] f, output logic lost);
      logic [31:0] mag;
      int          p;
      mag  = v[31] ? (~v + 32'd1) : v;
      lost = 1'b0;
      f    = '0;
      if (mag != 0) begin
         p = 0;
         for (int i = 0; i < 32; i++) if (mag[i]) p = i;
         if (p <= 23) begin
            f = {v[31], 8'(127 + p), 23'(mag << (23 - p))};
         end else begin
            lost = ((mag & ((32'd1 << (p - 23)) - 32'd1)) != 0);
            f    = {v[31], 8'(127 + p), 23'(mag >> (p - 23))};
         end
      end
   endtask

   // Presents av, counts edges from the accept edge (inclusive) until out_valid, then takes it.
   task automatic convert(input logic [31:0] av, output logic [31:0] dv,
                          output logic pl, output logic inv, output int lat);
      @(negedge clk);
      a = av;
      in_valid = 1'b1;
      check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         in_valid = 1'b0;
         lat++;
      end while (!out_valid && lat < 40);
      dv  = d;
      pl  = p_lost;
      inv = invalid;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("out_valid_after_take", {31'b0, out_valid}, 32'd0);
   endtask

   task automatic conv_vs_model(input string tag, input logic [31:0] av);
      logic [31:0] dv, ed;
      logic        pl, inv, epl, einv;
      int          lat;
      convert(av, dv, pl, inv, lat);
      ref_model(av, ed, epl, einv);
      check({tag, "_lat"}, lat, exp_latency(av));
      check({tag, "_d"}, dv, ed);
      check({tag, "_plost"}, {31'b0, pl}, {31'b0, epl});
      check({tag, "_inv"}, {31'b0, inv}, {31'b0, einv});
   endtask

   task automatic conv_const(input string tag, input logic [31:0] av, input int elat,
                             input logic [31:0] ed, input logic epl, input logic einv);
      logic [31:0] dv;
      logic        pl, inv;
      int          lat;
      convert(av, dv, pl, inv, lat);
      check({tag, "_lat"}, lat, elat);
      check({tag, "_d"}, dv, ed);
      check({tag, "_plost"}, {31'b0, pl}, {31'b0, epl});
      check({tag, "_inv"}, {31'b0, inv}, {31'b0, einv});
   endtask

   initial begin
      logic [31:0] v, f, dv, held_d;
      logic        lost, pl, inv;
      int          lat, n;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_in_ready", {31'b0, in_ready}, 32'd0);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_d", d, 32'd0);
      check("rst_plost", {31'b0, p_lost}, 32'd0);
      check("rst_inv", {31'b0, invalid}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", {31'b0, in_ready}, 32'd1);

      // Directed cases with hand-derived expectations
      conv_const("one",     32'h3F80_0000, 25, 32'h0000_0001, 1'b0, 1'b0);
      conv_const("negpi",   32'hC049_0FDB, 24, 32'hFFFF_FFFD, 1'b1, 1'b0);
      conv_const("maxleft", 32'h4EFF_FFFF,  9, 32'h7FFF_FF80, 1'b0, 1'b0);
      conv_const("min_int", 32'hCF00_0000,  1, 32'h8000_0000, 1'b0, 1'b0);
      conv_const("pos2p31", 32'h4F00_0000,  1, 32'h8000_0000, 1'b0, 1'b1);
      conv_const("qnan",    32'h7FC0_0000,  1, 32'h8000_0000, 1'b0, 1'b1);
      conv_const("neginf",  32'hFF80_0000,  1, 32'h8000_0000, 1'b0, 1'b1);
      conv_const("half",    32'h3F00_0000,  1, 32'h0000_0000, 1'b1, 1'b0);
      conv_const("negzero", 32'h8000_0000,  1, 32'h0000_0000, 1'b0, 1'b0);
      conv_const("denorm",  32'h0000_0001,  1, 32'h0000_0000, 1'b1, 1'b0);
      conv_const("e150",    32'h4B00_0001,  2, 32'h0080_0001, 1'b0, 1'b0);

      // Backpressure: result held, second operand not accepted
      @(negedge clk);
      a = 32'hC049_0FDB;
      in_valid = 1'b1;
      @(posedge clk);
      n = 0;
      do begin
         @(negedge clk);
         in_valid = 1'b0;
         n++;
      end while (!out_valid && n < 40);
      check("bp_reached_done", {31'b0, out_valid}, 32'd1);
      held_d = d;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         a = 32'h3F80_0000;
         @(negedge clk);
         check("bp_d_held", d, 32'hFFFF_FFFD);
         check("bp_plost_held", {31'b0, p_lost}, 32'd1);
         check("bp_out_valid", {31'b0, out_valid}, 32'd1);
         check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp_released_out_valid", {31'b0, out_valid}, 32'd0);
      check("bp_released_in_ready", {31'b0, in_ready}, 32'd1);
      check("bp_released_d_kept", d, held_d);

      // Reset in the middle of SHIFT aborts the conversion
      a = 32'h3F80_0000;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      check("midrst_d", d, 32'd0);
      check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
      rst = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (out_valid) break;
      end
      check("midrst_no_emit", {31'b0, out_valid}, 32'd0);
      check("midrst_idle", {31'b0, in_ready}, 32'd1);

      // Random floats around the interesting exponent band, then fully random words
      for (int i = 0; i < 60; i++)
         conv_vs_model("rnd_band", {1'($urandom), 8'($urandom_range(120, 160)), 23'($urandom)});
      for (int i = 0; i < 20; i++)
         conv_vs_model("rnd_any", $urandom);

      // Round trip through an i2f model
      for (int i = 0; i < 40; i++) begin
         if (i % 4 == 3) v = $urandom;
         else begin
            v = ($urandom & 32'h00FF_FFFF) << $urandom_range(0, 8);
            if ($urandom_range(0, 1) == 1) v = ~v + 32'd1;
         end
         if (i == 0) v = 32'h8000_0000;
         i2f(v, f, lost);
         if (!lost) begin
            convert(f, dv, pl, inv, lat);
            check("rt_d", dv, v);
            check("rt_plost", {31'b0, pl}, 32'd0);
            check("rt_inv", {31'b0, inv}, 32'd0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/f2i_seq.md
Name: f2i_seq

Overview:
- Multi-cycle IEEE-754 single-precision to signed int32 converter. It is the inverse of the i2f stage and consumes the float words that stage produces.
- Conversion truncates toward zero, matching a C cast.
- The significand is shifted one bit per cycle, so the datapath is a single 32-bit shifter register.
- Valid/ready handshakes sit on both sides, so the block can be chained after i2f for round-trip checking or driven by the FPU result bus.

Parameters:
none (format fixed: binary32 in, int32 out)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  a is presented
- in_ready  output  1  block can accept a
- a  input  32  IEEE-754 single (sign a[31], exp a[30:23], frac a[22:0])
- out_valid  output  1  d, p_lost and invalid are valid
- out_ready  input  1  consumer takes the result
- d  output  32  signed int32 result
- p_lost  output  1  nonzero fraction bits were discarded
- invalid  output  1  NaN, Inf or out of int32 range

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; d=0, p_lost=0, invalid=0, out_valid=0.
  - in_ready=0 while rst=1.
  - Reset at any state aborts the conversion in flight. Nothing is emitted.
- States:
  - IDLE: in_ready=1.
  - SHIFT: in_ready=0, out_valid=0.
  - DONE: out_valid=1, in_ready=0.
- Accept happens on the edge where IDLE & in_valid. The operand is classified at that edge (e = a[30:23]):
  - e==255 (Inf/NaN): d=0x80000000, invalid=1, p_lost=0. Go to DONE.
  - e>=158: d=0x80000000, p_lost=0. invalid=0 only for a==0xCF000000 (exactly -2^31), otherwise invalid=1. Go to DONE.
  - e<127 (|x|<1, includes zero and denormals): d=0, invalid=0. p_lost=1 iff a[30:0]!=0. Go to DONE.
  - 127<=e<=157:
    - Load m={8'b0,1,frac}. Clear sticky.
    - e<150: direction=right, cnt=150-e (1..23).
    - e>=150: direction=left, cnt=e-150 (0..7).
    - Go to SHIFT.
- SHIFT, each edge:
  - cnt!=0: m shifts one bit in direction, cnt decrements. On a right shift, sticky |= m[0] (the bit dropped).
  - cnt==0 (finalize): d = sign ? -m : m (32-bit two's complement), p_lost=sticky, invalid=0. Go to DONE.
- Latency from the accept edge to out_valid=1:
  - Special cases: 1 edge.
  - Normal path: cnt+2 edges (shift edges, finalize, then visible). Value range 2..25.
- DONE:
  - d, p_lost and invalid are held stable while out_ready=0.
  - On the edge with out_ready=1: go to IDLE. out_valid drops. d, p_lost and invalid keep their last values.
- No overlap: a new operand is accepted only in IDLE, one edge after the result is taken. Throughput is one result per (latency+1) cycles minimum.
- in_valid and a are ignored outside IDLE. Upstream must hold a until accepted.
- No overflow is possible on the normal path: the maximum magnitude is 0xFFFFFF<<7 = 0x7FFFFF80.

Test Plan:
- a=0x3F800000 (1.0) → cnt=23, out_valid 25 edges after accept. d=0x00000001, p_lost=0, invalid=0.
- a=0xC0490FDB (-3.1415927) → d=0xFFFFFFFD, p_lost=1, invalid=0. a=0x4EFFFFFF → d=0x7FFFFF80, p_lost=0, invalid=0 (left-shift path).
- Specials, each out_valid 1 edge after accept:
  - 0xCF000000 → d=0x80000000, invalid=0.
  - 0x4F000000 → d=0x80000000, invalid=1.
  - 0x7FC00000 → invalid=1.
  - 0xFF800000 → invalid=1.
- Small magnitudes:
  - 0x3F000000 (0.5) → d=0, p_lost=1.
  - 0x80000000 (-0) → d=0, p_lost=0.
  - 0x00000001 (denormal) → d=0, p_lost=1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE → d/flags constant, in_ready=0, a second in_valid is not accepted. Then out_ready=1 → IDLE next edge.
  - Assert rst mid-SHIFT → next cycle out_valid=0, d=0, IDLE.
- Round trip: i2f output fed back into this block for random int32 values. Whenever i2f p_lost=0, d equals the original integer and p_lost=0.
